// File: rtl/microprocessor_mc_control_fsm.sv
// Multi-cycle control sequencer for the RV32I-subset core: one micro-step per clock,
// with req/ready handshakes to instruction and data memory, a stall timeout and a sticky trap.
module microprocessor_mc_control_fsm #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [6:0]            opcode,
    input  logic                  alu_zero,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    output logic                  imem_req,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  reg_write,
    output logic                  memtoreg,
    output logic                  wb_pc4,
    output logic                  alu_src_b,
    output logic [1:0]            alu_op,
    output logic [3:0]            state,
    output logic                  trap,
    output logic [DATA_WIDTH-1:0] cycle_cnt,
    output logic [DATA_WIDTH-1:0] instret_cnt
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_ACC  = 4'd5,
        S_WB       = 4'd6,
        S_BRANCH   = 4'd7,
        S_JAL      = 4'd8,
        S_TRAP     = 4'd9
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;

    localparam int SW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [SW-1:0] STALL_LIMIT = (MEM_TIMEOUT == 0) ? '0 : SW'(MEM_TIMEOUT - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [SW-1:0]           r_stall;
    logic                    r_memtoreg;
    logic [DATA_WIDTH-1:0]   r_cycle_cnt;
    logic [DATA_WIDTH-1:0]   r_instret_cnt;
    logic                    w_req;
    logic                    w_rdy;
    logic                    w_retire;
    logic                    w_is_store;

    assign w_is_store  = (opcode == OP_STORE);
    assign state       = r_state;
    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;

    // Everything is qualified by arst_n so that asserting reset mid-access drops
    // requests and enables at once, even though the reset state is FETCH.
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_rdy     = 1'b0;
        w_retire  = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        reg_write = 1'b0;
        memtoreg  = 1'b0;
        wb_pc4    = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        trap      = 1'b0;
        if (arst_n) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    w_req    = 1'b1;
                    w_rdy    = imem_ready;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 2'b00;
                        w_next   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_R:              w_next = S_EXEC_R;
                        OP_I:              w_next = S_EXEC_I;
                        OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                        OP_B:              w_next = S_BRANCH;
                        OP_J:              w_next = S_JAL;
                        default:           w_next = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    alu_op = 2'b10;
                    w_next = S_WB;
                end
                S_EXEC_I: begin
                    alu_src_b = 1'b1;
                    alu_op    = 2'b10;
                    w_next    = S_WB;
                end
                S_MEM_ADDR: begin
                    alu_src_b = 1'b1;
                    alu_op    = 2'b00;
                    w_next    = S_MEM_ACC;
                end
                S_MEM_ACC: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_is_store;
                    w_req    = 1'b1;
                    w_rdy    = dmem_ready;
                    if (dmem_ready) begin
                        if (w_is_store) begin
                            w_next   = S_FETCH;
                            w_retire = 1'b1;
                        end else begin
                            w_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    memtoreg  = r_memtoreg;
                    w_retire  = 1'b1;
                    w_next    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_op = 2'b01;
                    if (alu_zero) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                    end
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
                S_JAL: begin
                    reg_write = 1'b1;
                    wb_pc4    = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = 2'b10;
                    w_retire  = 1'b1;
                    w_next    = S_FETCH;
                end
                S_TRAP: begin
                    trap   = 1'b1;
                    w_next = S_TRAP;
                end
                default: w_next = S_FETCH;
            endcase
            // A request stalled for MEM_TIMEOUT consecutive cycles overrides the normal flow.
            if ((MEM_TIMEOUT != 0) && w_req && !w_rdy && (r_stall == STALL_LIMIT)) begin
                w_next = S_TRAP;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall <= '0;
        end else if ((w_next != r_state) || !(w_req && !w_rdy)) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_memtoreg <= 1'b0;
        end else if ((r_state == S_MEM_ACC) && (w_next == S_WB)) begin
            r_memtoreg <= 1'b1;
        end else if (r_state == S_WB) begin
            r_memtoreg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_TRAP) begin
                r_cycle_cnt <= r_cycle_cnt + DATA_WIDTH'(1);
            end
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + DATA_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_microprocessor_mc_control_fsm.sv
// Directed bench for the multi-cycle control sequencer: per-cycle control vectors
// are compared against hand-written expectations for each instruction class.
module tb_microprocessor_mc_control_fsm;

    logic        clk;
    logic        arst_n;
    logic [6:0]  opcode;
    logic        alu_zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        memtoreg;
    logic        wb_pc4;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic [3:0]  state;
    logic        trap;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int checks   = 0;
    int failures = 0;

    logic [17:0] obs;
    assign obs = {state, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                  reg_write, memtoreg, wb_pc4, alu_src_b, alu_op, trap};

    microprocessor_mc_control_fsm #(.DATA_WIDTH(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .arst_n(arst_n), .opcode(opcode), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .memtoreg(memtoreg), .wb_pc4(wb_pc4),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .trap(trap),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected control vector builder, argument order matches obs.
    function automatic logic [17:0] ctl(input logic [3:0] st, input logic ireq, input logic dreq,
                                        input logic we, input logic irw, input logic pcw,
                                        input logic [1:0] pcs, input logic rw, input logic m2r,
                                        input logic pc4, input logic asb, input logic [1:0] aop,
                                        input logic tr);
        return {st, ireq, dreq, we, irw, pcw, pcs, rw, m2r, pc4, asb, aop, tr};
    endfunction

    logic [17:0] e_rst, f_go, f_wait, e_dec, e_exr, e_exi, e_wb, e_wbld;
    logic [17:0] e_brt, e_brn, e_ma, e_macc_ld, e_macc_st, e_jal, e_trap;

    task automatic do_reset();
        arst_n     = 1'b0;
        opcode     = 7'b0;
        alu_zero   = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        arst_n = 1'b1;
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        checks++;
        if (obs !== e_rst) begin
            failures++;
            $display("FAIL reset_ctl: got %h want %h", obs, e_rst);
        end
        checks++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
        end
    endtask

    task automatic test_addi();
        logic [17:0] e [4];
        e = '{f_go, e_dec, e_exi, e_wb};
        do_reset();
        opcode = 7'b0010011;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL addi_cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (obs !== f_go || cycle_cnt !== 32'd4 || instret_cnt !== 32'd1) begin
            failures++;
            $display("FAIL addi_done: ctl %h cyc %0d ret %0d want %h 4 1", obs, cycle_cnt, instret_cnt, f_go);
        end
    endtask

    task automatic test_branch();
        logic [17:0] e [6];
        logic        z [6];
        e = '{f_go, e_dec, e_brt, f_go, e_dec, e_brn};
        z = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        opcode = 7'b1100011;
        for (int i = 0; i < 6; i++) begin
            alu_zero = z[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL beq_cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (cycle_cnt !== 32'd6 || instret_cnt !== 32'd2) begin
            failures++;
            $display("FAIL beq_counts: got %0d/%0d want 6/2", cycle_cnt, instret_cnt);
        end
    endtask

    task automatic test_load_stall();
        logic [17:0] e [8];
        logic        r [8];
        int          req_cycles;
        e = '{f_go, e_dec, e_ma, e_macc_ld, e_macc_ld, e_macc_ld, e_macc_ld, e_wbld};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        req_cycles = 0;
        do_reset();
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            dmem_ready = r[i];
            #1;
            if (dmem_req) req_cycles++;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL lw_cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (req_cycles != 4 || cycle_cnt !== 32'd8 || instret_cnt !== 32'd1 || trap !== 1'b0) begin
            failures++;
            $display("FAIL lw_done: req %0d cyc %0d ret %0d trap %b want 4 8 1 0",
                     req_cycles, cycle_cnt, instret_cnt, trap);
        end
    endtask

    task automatic test_store();
        logic [17:0] e [4];
        e = '{f_go, e_dec, e_ma, e_macc_st};
        do_reset();
        opcode = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL sw_cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (obs !== f_go || cycle_cnt !== 32'd4 || instret_cnt !== 32'd1) begin
            failures++;
            $display("FAIL sw_done: ctl %h cyc %0d ret %0d want %h 4 1", obs, cycle_cnt, instret_cnt, f_go);
        end
    endtask

    task automatic test_jal();
        logic [17:0] e [3];
        e = '{f_go, e_dec, e_jal};
        do_reset();
        opcode = 7'b1101111;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL jal_cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (cycle_cnt !== 32'd3 || instret_cnt !== 32'd1) begin
            failures++;
            $display("FAIL jal_counts: got %0d/%0d want 3/1", cycle_cnt, instret_cnt);
        end
    endtask

    task automatic test_illegal();
        int bad;
        do_reset();
        opcode = 7'b1111111;
        #1;
        checks++;
        if (obs !== f_go) begin
            failures++;
            $display("FAIL ill_fetch: got %h want %h", obs, f_go);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs !== e_dec) begin
            failures++;
            $display("FAIL ill_decode: got %h want %h", obs, e_dec);
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            alu_zero   = 1'($urandom_range(0, 1));
            #1;
            if (obs !== e_trap || cycle_cnt !== 32'd2 || instret_cnt !== 32'd0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ill_trap_hold: %0d bad cycles, last ctl %h cyc %0d want %h cyc 2",
                     bad, obs, cycle_cnt, e_trap);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if (obs !== e_rst || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            failures++;
            $display("FAIL ill_reset: ctl %h cyc %0d ret %0d want %h 0 0", obs, cycle_cnt, instret_cnt, e_rst);
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        opcode     = 7'b0110011;
        imem_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (obs !== f_wait) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL timeout_wait: %0d bad cycles, got %h want %h", bad, obs, f_wait);
        end
        #1;
        checks++;
        if (obs !== e_trap || cycle_cnt !== 32'd16) begin
            failures++;
            $display("FAIL timeout_trap: ctl %h cyc %0d want %h 16", obs, cycle_cnt, e_trap);
        end
    endtask

    task automatic test_stall_no_trap();
        logic [17:0] e [4];
        e = '{f_go, e_dec, e_exr, e_wb};
        do_reset();
        opcode     = 7'b0110011;
        imem_ready = 1'b0;
        repeat (15) @(negedge clk);
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL stall15_cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (cycle_cnt !== 32'd19 || instret_cnt !== 32'd1 || trap !== 1'b0) begin
            failures++;
            $display("FAIL stall15_done: cyc %0d ret %0d trap %b want 19 1 0", cycle_cnt, instret_cnt, trap);
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        opcode     = 7'b0000011;
        dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs !== e_macc_ld) begin
            failures++;
            $display("FAIL midrst_pre: got %h want %h", obs, e_macc_ld);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if (obs !== e_rst) begin
            failures++;
            $display("FAIL midrst_drop: got %h want %h", obs, e_rst);
        end
        @(negedge clk);
        arst_n = 1'b1;
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== f_go || cycle_cnt !== 32'd0) begin
            failures++;
            $display("FAIL midrst_release: ctl %h cyc %0d want %h 0", obs, cycle_cnt, f_go);
        end
    endtask

    initial begin
        arst_n     = 1'b1;
        opcode     = 7'b0;
        alu_zero   = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        e_rst     = ctl(4'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        f_go      = ctl(4'd0, 1, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        f_wait    = ctl(4'd0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        e_dec     = ctl(4'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        e_exr     = ctl(4'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0);
        e_exi     = ctl(4'd3, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 0);
        e_ma      = ctl(4'd4, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 0);
        e_macc_ld = ctl(4'd5, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        e_macc_st = ctl(4'd5, 0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        e_wb      = ctl(4'd6, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0);
        e_wbld    = ctl(4'd6, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 0);
        e_brt     = ctl(4'd7, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 2'd1, 0);
        e_brn     = ctl(4'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd1, 0);
        e_jal     = ctl(4'd8, 0, 0, 0, 0, 1, 2'd2, 1, 0, 1, 0, 2'd0, 0);
        e_trap    = ctl(4'd9, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1);

        test_reset();
        test_addi();
        test_branch();
        test_load_stall();
        test_store();
        test_jal();
        test_illegal();
        test_timeout();
        test_stall_no_trap();
        test_reset_mid_access();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microprocessor_mc_control_fsm.md
Name: microprocessor_mc_control_fsm

Overview:
- Multi-cycle sequencer for the RV32I-subset core (PC, register bank, ALU, immediate generator, PC/immediate muxes, instruction and data memory).
- Replaces single-cycle combinational decode with an FSM that issues one micro-step per clock: fetch, decode, execute, memory, writeback.
- Handshakes with instruction and data memory through req/ready, so memories may stall.
- Supported opcodes: R-type 0110011, I-type ALU 0010011, load 0000011, store 0100011, B-type 1100011, J-type 1101111. Any other opcode traps.

Parameters:
- DATA_WIDTH, 32, width of the cycle and retired-instruction counters.
- MEM_TIMEOUT, 16, consecutive stalled cycles on one memory request before trapping; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- arst_n  input  1  asynchronous active-low reset
- opcode  input  7  instruction[6:0] taken from the instruction register
- alu_zero  input  1  ALU zero flag (rs1 == rs2 for branch compare)
- imem_ready  input  1  instruction memory accepts/returns this cycle
- dmem_ready  input  1  data memory completes access this cycle
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write enable (store)
- ir_write  output  1  load instruction register
- pc_write  output  1  update PC
- pc_src  output  2  00 = pc+4, 01 = branch target (pc_old+imm), 10 = jal target (pc_old+imm)
- reg_write  output  1  register bank write enable
- memtoreg  output  1  writeback selects memory data
- wb_pc4  output  1  writeback selects pc_old+4 (jal link)
- alu_src_b  output  1  0 = rs2, 1 = imm_out
- alu_op  output  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- state  output  4  current state encoding, for debug and assertions
- trap  output  1  sticky illegal-opcode or timeout flag
- cycle_cnt  output  DATA_WIDTH  clocks since reset, excluding TRAP
- instret_cnt  output  DATA_WIDTH  retired instructions

Behaviour:
- Reset (arst_n = 0, asynchronous): state = FETCH (0). All control outputs, trap and both counters = 0. FETCH outputs appear in the first cycle after release.
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_ACC 5, WB 6, BRANCH 7, JAL 8, TRAP 9.
- All outputs are decoded from state; ready and alu_zero gate them in the same cycle (Mealy on handshake).
- FETCH:
  - imem_req = 1 every cycle until imem_ready.
  - On imem_ready: ir_write = 1, pc_write = 1, pc_src = 00, go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle, no writes). Next state by opcode:
  - R-type -> EXEC_R
  - I-type -> EXEC_I
  - load or store -> MEM_ADDR
  - B-type -> BRANCH
  - J-type -> JAL
  - any other opcode -> TRAP
- EXEC_R: alu_src_b = 0, alu_op = 10, then WB.
- EXEC_I: alu_src_b = 1, alu_op = 10, then WB.
- MEM_ADDR: alu_src_b = 1, alu_op = 00, then MEM_ACC.
- MEM_ACC:
  - dmem_req = 1; dmem_we = 1 only if opcode is store.
  - Hold until dmem_ready, then: load -> WB with memtoreg latched = 1; store -> FETCH and the instruction retires.
- WB: reg_write = 1 for one cycle, memtoreg per latched flag, then FETCH; the instruction retires.
- BRANCH: alu_src_b = 0, alu_op = 01. If alu_zero: pc_write = 1, pc_src = 01. Then FETCH; the instruction retires whether or not the branch is taken.
- JAL: reg_write = 1, wb_pc4 = 1, pc_write = 1, pc_src = 10, then FETCH; the instruction retires.
- Cycle counts per instruction (zero-wait memory): R/I 4, load 5, store 4, branch 3, jal 3.
- Retire: instret_cnt increments by 1 in the cycle the instruction retires.
- cycle_cnt increments every cycle outside TRAP. Both counters wrap modulo 2^DATA_WIDTH.
- Timeout: a stall counter counts consecutive cycles with req = 1 and ready = 0. Reaching MEM_TIMEOUT -> TRAP. The counter clears whenever ready = 1 or the state changes.
- TRAP is absorbing until reset:
  - trap = 1, all enables 0, counters frozen.
  - imem_req/dmem_req drop the same cycle TRAP is entered.
- Ready asserted while no request is outstanding is ignored.
- Reset mid-operation (e.g. during MEM_ACC): requests drop immediately and no write enable is asserted.
- At most one of reg_write, dmem_we, ir_write is high in any cycle.

Test Plan:
- Reset, then addi (0010011) with imem_ready/dmem_ready tied 1 -> states 0,1,3,6,0. reg_write high only in cycle 4; instret_cnt = 1; cycle_cnt = 4.
- beq (1100011) with alu_zero = 1 -> pc_write with pc_src = 01 in BRANCH. Repeat with alu_zero = 0 -> no pc_write in BRANCH. instret_cnt increments in both cases.
- lw with dmem_ready low for 3 cycles -> dmem_req held 4 cycles, then WB with memtoreg = 1, reg_write = 1. Total 8 cycles; no trap.
- sw -> dmem_we = 1 only while in MEM_ACC, reg_write never asserted, return to FETCH after dmem_ready.
- Illegal opcode 1111111 -> TRAP in the cycle after DECODE; trap = 1; all enables 0; counters frozen. Hold 20 cycles, then apply arst_n = 0 -> everything returns to 0.
- imem_ready held low for 16 cycles (MEM_TIMEOUT = 16) -> trap = 1. Also assert arst_n mid-MEM_ACC -> dmem_req = 0 in the same cycle.
